// File: rtl/jk_pkg.sv
// Shared JK flip-flop excitation codes and the per-bit excitation function.
// Excitation codes are packed as {J,K}.
package jk_pkg;
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Don't-cares resolve to 0, so TOGGLE is never produced.
    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
        return {~cur & nxt, cur & ~nxt};
    endfunction
endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset.
// One cycle latency: q updates on the posedge after J/K are presented.
import jk_pkg::*;

module jk_cell (
    input  logic CLK,
    input  logic RST,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
            endcase
        end
    end
endmodule

// File: rtl/jk_mod_counter.sv
// Loadable modulo-N up/down counter built on a bank of JK flip-flops.
// Next state and J/K excitation are combinational; q and wrap update one cycle later.
import jk_pkg::*;

module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_ex,
    output logic [WIDTH-1:0] k_ex,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] eff;
    logic             wrap_nxt;

    always_comb begin
        nxt      = q;
        wrap_nxt = 1'b0;
        // An out-of-range count behaves as the top of the range.
        eff      = (q > MAX) ? MAX : q;
        if (load) begin
            nxt = ({1'b0, load_val} >= MOD_W) ? MAX : load_val;
        end else if (en && up) begin
            if (eff == MAX) begin
                nxt      = '0;
                wrap_nxt = 1'b1;
            end else begin
                nxt = eff + WIDTH'(1);
            end
        end else if (en) begin
            if (q == '0) begin
                nxt      = MAX;
                wrap_nxt = 1'b1;
            end else begin
                nxt = eff - WIDTH'(1);
            end
        end
    end

    always_comb begin
        j_ex = '0;
        k_ex = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_ex[i], k_ex[i]} = jk_excite(q[i], nxt[i]);
        end
    end

    assign tc = en & ~load & ((up & (q == MAX)) | (~up & (q == '0)));

    for (genvar g = 0; g < WIDTH; g++) begin : g_bank
        jk_cell u_cell (
            .CLK (CLK),
            .RST (RST),
            .j   (j_ex[g]),
            .k   (k_ex[g]),
            .q   (q[g])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) wrap <= 1'b0;
        else     wrap <= wrap_nxt;
    end
endmodule

// File: tb/tb_jk_mod_counter.sv
// Drives a modulo-10 and a modulo-16 counter with shared stimulus and
// compares both against an arithmetic model of the counting rules.
module tb_jk_mod_counter;
    logic       clk = 1'b0;
    logic       rst;
    logic       en_i, up_i, ld;
    logic [3:0] lv;
    logic [3:0] q10, j10, k10, q16, j16, k16;
    logic       tc10, wr10, tc16, wr16;

    int checks = 0;
    int errors = 0;
    int m10, m16, n10, n16, w10, w16;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .CLK(clk), .RST(rst), .en(en_i), .up(up_i), .load(ld), .load_val(lv),
        .q(q10), .j_ex(j10), .k_ex(k10), .tc(tc10), .wrap(wr10)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .CLK(clk), .RST(rst), .en(en_i), .up(up_i), .load(ld), .load_val(lv),
        .q(q16), .j_ex(j16), .k_ex(k16), .tc(tc16), .wrap(wr16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counting rules written as plain modular arithmetic.
    task automatic mstep(input int modulus, inout int m, output int w);
        w = 0;
        if (ld) begin
            m = (int'(lv) >= modulus) ? modulus - 1 : int'(lv);
        end else if (en_i && up_i) begin
            w = (m == modulus - 1) ? 1 : 0;
            m = (m + 1) % modulus;
        end else if (en_i) begin
            w = (m == 0) ? 1 : 0;
            m = (m + modulus - 1) % modulus;
        end
    endtask

    task automatic step(input string tag, input logic e, input logic u,
                        input logic l, input logic [3:0] v);
        en_i = e; up_i = u; ld = l; lv = v;
        #1;
        n10 = m10; mstep(10, n10, w10);
        n16 = m16; mstep(16, n16, w16);
        chk({tag, ".j10"}, 32'(j10), 32'(~m10 & n10 & 15));
        chk({tag, ".k10"}, 32'(k10), 32'(m10 & ~n10 & 15));
        chk({tag, ".tc10"}, 32'(tc10), 32'(w10));
        chk({tag, ".jk10"}, 32'(j10 & k10), 32'd0);
        chk({tag, ".j16"}, 32'(j16), 32'(~m16 & n16 & 15));
        chk({tag, ".k16"}, 32'(k16), 32'(m16 & ~n16 & 15));
        chk({tag, ".tc16"}, 32'(tc16), 32'(w16));
        chk({tag, ".jk16"}, 32'(j16 & k16), 32'd0);
        @(posedge clk);
        #1;
        m10 = n10;
        m16 = n16;
        chk({tag, ".q10"}, 32'(q10), 32'(m10));
        chk({tag, ".wrap10"}, 32'(wr10), 32'(w10));
        chk({tag, ".q16"}, 32'(q16), 32'(m16));
        chk({tag, ".wrap16"}, 32'(wr16), 32'(w16));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en_i = 1'b0; up_i = 1'b1; ld = 1'b0; lv = 4'd0;
        m10 = 0; m16 = 0;
        #2;
        chk("reset.q10", 32'(q10), 32'd0);
        chk("reset.wrap10", 32'(wr10), 32'd0);
        chk("reset.q16", 32'(q16), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Async reset mid-count, then three up-counts.
        step("t1.load7", 1'b0, 1'b1, 1'b1, 4'd7);
        chk("t1.q_at7", 32'(q10), 32'd7);
        #3;
        rst = 1'b1;
        #1;
        chk("t1.async_q10", 32'(q10), 32'd0);
        chk("t1.async_wrap10", 32'(wr10), 32'd0);
        chk("t1.async_q16", 32'(q16), 32'd0);
        m10 = 0; m16 = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("t1.up", 1'b1, 1'b1, 1'b0, 4'd0);
        chk("t1.q_after3", 32'(q10), 32'd3);

        // Up wrap 8 -> 9 -> 0 -> 1.
        step("t2.load8", 1'b0, 1'b1, 1'b1, 4'd8);
        step("t2.e1", 1'b1, 1'b1, 1'b0, 4'd0);
        chk("t2.q9", 32'(q10), 32'd9);
        chk("t2.tc", 32'(tc10), 32'd1);
        step("t2.e2", 1'b1, 1'b1, 1'b0, 4'd0);
        chk("t2.q0", 32'(q10), 32'd0);
        chk("t2.wrap", 32'(wr10), 32'd1);
        step("t2.e3", 1'b1, 1'b1, 1'b0, 4'd0);
        chk("t2.q1", 32'(q10), 32'd1);
        chk("t2.wrap_off", 32'(wr10), 32'd0);

        // Down wrap 1 -> 0 -> 9 -> 8.
        step("t3.load1", 1'b0, 1'b0, 1'b1, 4'd1);
        step("t3.e1", 1'b1, 1'b0, 1'b0, 4'd0);
        chk("t3.tc", 32'(tc10), 32'd1);
        step("t3.e2", 1'b1, 1'b0, 1'b0, 4'd0);
        chk("t3.q9", 32'(q10), 32'd9);
        chk("t3.wrap", 32'(wr10), 32'd1);
        step("t3.e3", 1'b1, 1'b0, 1'b0, 4'd0);
        chk("t3.q8", 32'(q10), 32'd8);

        // Load priority and saturation.
        step("t4.load6", 1'b1, 1'b1, 1'b1, 4'd6);
        chk("t4.q6", 32'(q10), 32'd6);
        step("t4.load13", 1'b1, 1'b1, 1'b1, 4'd13);
        chk("t4.q9", 32'(q10), 32'd9);
        chk("t4.q16_13", 32'(q16), 32'd13);
        step("t4.load_noen", 1'b0, 1'b0, 1'b1, 4'd3);
        chk("t4.q3", 32'(q10), 32'd3);

        // Excitation at 0101 counting up.
        step("t5.load5", 1'b0, 1'b1, 1'b1, 4'd5);
        en_i = 1'b1; up_i = 1'b1; ld = 1'b0;
        #1;
        chk("t5.j_ex", 32'(j10), 32'b0010);
        chk("t5.k_ex", 32'(k10), 32'b0001);
        step("t5.edge", 1'b1, 1'b1, 1'b0, 4'd0);
        chk("t5.q6", 32'(q10), 32'd6);

        // Hold for 20 cycles, then 15 -> 0 on the modulo-16 counter.
        step("t6.load4", 1'b0, 1'b1, 1'b1, 4'd4);
        for (int i = 0; i < 20; i++) step("t6.hold", 1'b0, i[0], 1'b0, 4'(i));
        chk("t6.q4", 32'(q10), 32'd4);
        chk("t6.tc", 32'(tc10), 32'd0);
        chk("t6.wrap", 32'(wr10), 32'd0);
        step("t6.load15", 1'b0, 1'b1, 1'b1, 4'd15);
        step("t6.wrap16", 1'b1, 1'b1, 1'b0, 4'd0);
        chk("t6.q16_0", 32'(q16), 32'd0);
        chk("t6.wrap16_1", 32'(wr16), 32'd1);

        // Randomized traffic, including direction changes mid-count.
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(3) != 0), 1'($urandom),
                 ($urandom_range(7) == 0), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
